// File: rtl/mem_lsu_pkg.sv
// Shared types for the load/store unit: memory access size, the control
// vector fields it consumes, FSM states and the alignment rule.
package mem_lsu_pkg;

    typedef enum logic [1:0] {
        MEM_B = 2'b00,
        MEM_H = 2'b01,
        MEM_W = 2'b10
    } mem_size_t;

    typedef struct packed {
        logic      branch;
        logic      branch_neq;
        mem_size_t mem_size;
        logic      mem_unsigned;
    } riscv_control_t;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } lsu_state_t;

    // Wide enough to hold LATENCY-1 for LATENCY up to 4.
    localparam int CNT_W = 2;

    // Halfwords need an even address; words (and the unused size 11) need
    // a four-byte aligned address; bytes are always aligned.
    function automatic logic misaligned_access(mem_size_t size, logic [1:0] lane);
        logic bad;
        case (size)
            MEM_B:   bad = 1'b0;
            MEM_H:   bad = lane[0];
            default: bad = (lane != 2'b00);
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// Picks the addressed byte or halfword out of a memory word and extends it
// to the full width (zero- or sign-extension).
module lsu_align
    import mem_lsu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] word,
    input  logic [1:0]       lane,
    input  mem_size_t        size,
    input  logic             is_unsigned,
    output logic [WIDTH-1:0] result
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    // Lane extraction and extension; size 11 behaves as a full word.
    always_comb begin
        lane_byte = word[{lane, 3'b000} +: 8];
        lane_half = word[{lane[1], 4'b0000} +: 16];
        case (size)
            MEM_B:   result = is_unsigned ? {{(WIDTH-8){1'b0}}, lane_byte}
                                          : {{(WIDTH-8){lane_byte[7]}}, lane_byte};
            MEM_H:   result = is_unsigned ? {{(WIDTH-16){1'b0}}, lane_half}
                                          : {{(WIDTH-16){lane_half[15]}}, lane_half};
            default: result = word;
        endcase
    end

endmodule

// File: rtl/mem_lsu_branch.sv
// Branch decision: taken on equal when zero is set, or on not-equal when clear.
module select_branch (
    input  logic branch,
    input  logic branch_neq,
    input  logic zero,
    output logic taken
);

    assign taken = (branch & zero) | (branch_neq & ~zero);

endmodule

// File: rtl/mem_lsu.sv
// Load/store unit: word-organised memory with byte-lane writes, a
// multi-cycle load path that stalls the pipeline, misalignment reporting
// and the branch-taken decision.
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int INDEX   = 5,
    parameter int LATENCY = 1
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 we_in,
    input  logic                 re_in,
    input  logic                 zero_in,
    input  riscv_control_t       ctrl_vector_in,
    input  logic [WIDTH-1:0]     address_in,
    input  logic [WIDTH-1:0]     data_in,
    output logic                 pc_src_out,
    output logic                 stall_out,
    output logic                 valid_out,
    output logic [WIDTH-1:0]     data_out,
    output logic                 misalign_out,
    output logic [WIDTH-1:0]     bad_addr_out
);

    localparam int LANES = WIDTH / 8;
    localparam int DEPTH = 2 ** INDEX;

    lsu_state_t       state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [WIDTH-1:0] mem [DEPTH];

    logic [INDEX-1:0] idx;
    logic [1:0]       lane;
    logic             misaligned;
    logic             store_go;
    logic             load_done;
    logic [LANES-1:0] lane_we;
    logic [WIDTH-1:0] store_data;
    logic [WIDTH-1:0] load_ext;

    assign idx        = address_in[INDEX+1:2];
    assign lane       = address_in[1:0];
    assign misaligned = misaligned_access(ctrl_vector_in.mem_size, lane);

    select_branch u_branch (
        .branch     (ctrl_vector_in.branch),
        .branch_neq (ctrl_vector_in.branch_neq),
        .zero       (zero_in),
        .taken      (pc_src_out)
    );

    lsu_align #(.WIDTH(WIDTH)) u_align (
        .word        (mem[idx]),
        .lane        (lane),
        .size        (ctrl_vector_in.mem_size),
        .is_unsigned (ctrl_vector_in.mem_unsigned),
        .result      (load_ext)
    );

    // Byte-lane enables and lane-replicated store data for the access size.
    always_comb begin
        case (ctrl_vector_in.mem_size)
            MEM_B: begin
                lane_we    = LANES'(1) << lane;
                store_data = {LANES{data_in[7:0]}};
            end
            MEM_H: begin
                lane_we    = LANES'(3) << lane;
                store_data = {(LANES/2){data_in[15:0]}};
            end
            default: begin
                lane_we    = '1;
                store_data = data_in;
            end
        endcase
    end

    // FSM state and load latency counter.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next state, stall and store strobe; a store wins over a simultaneous load.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        stall_out  = 1'b0;
        store_go   = 1'b0;
        load_done  = 1'b0;
        case (state)
            IDLE: begin
                if (we_in && !misaligned) begin
                    store_go = 1'b1;
                end else if (re_in && !misaligned) begin
                    stall_out  = 1'b1;
                    cnt_next   = CNT_W'(LATENCY - 1);
                    state_next = WAIT;
                end
            end
            WAIT: begin
                stall_out = 1'b1;
                if (cnt == '0) begin
                    load_done  = 1'b1;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
        if (rst_in) begin
            stall_out = 1'b0;
            store_go  = 1'b0;
        end
    end

    // Memory array: per-lane writes, contents survive reset.
    always_ff @(posedge clk_in) begin
        if (store_go) begin
            for (int i = 0; i < LANES; i++) begin
                if (lane_we[i]) begin
                    mem[idx][8*i +: 8] <= store_data[8*i +: 8];
                end
            end
        end
    end

    // Registered load result, valid pulse and misalignment report.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            valid_out    <= 1'b0;
            data_out     <= '0;
            misalign_out <= 1'b0;
            bad_addr_out <= '0;
        end else begin
            valid_out    <= load_done;
            misalign_out <= 1'b0;
            if (load_done) begin
                data_out <= load_ext;
            end
            if (state == IDLE && (we_in || re_in) && misaligned) begin
                misalign_out <= 1'b1;
                bad_addr_out <= address_in;
            end
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Randomised bench for mem_lsu against a byte-addressed memory model.
module tb_mem_lsu;
    import mem_lsu_pkg::*;

    localparam int W   = 32;
    localparam int IX  = 5;
    localparam int LAT = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic we = 1'b0, re = 1'b0, zero = 1'b0, br = 1'b0, brn = 1'b0, uns = 1'b0;
    logic [1:0] msz = 2'd0;
    logic [W-1:0] addr = '0, wdata = '0;
    riscv_control_t ctrl;

    logic pc_src, stall, valid, mis;
    logic [W-1:0] dout, bad;

    assign ctrl = '{branch: br, branch_neq: brn, mem_size: mem_size_t'(msz), mem_unsigned: uns};

    mem_lsu #(.WIDTH(W), .INDEX(IX), .LATENCY(LAT)) dut (
        .clk_in         (clk),
        .rst_in         (rst),
        .we_in          (we),
        .re_in          (re),
        .zero_in        (zero),
        .ctrl_vector_in (ctrl),
        .address_in     (addr),
        .data_in        (wdata),
        .pc_src_out     (pc_src),
        .stall_out      (stall),
        .valid_out      (valid),
        .data_out       (dout),
        .misalign_out   (mis),
        .bad_addr_out   (bad)
    );

    always #5 clk = ~clk;

    // Reference state
    logic [7:0]   mem_m [0:(4<<IX)-1];
    logic         exp_stall = 1'b0, exp_valid = 1'b0, exp_mis = 1'b0;
    logic [W-1:0] exp_data = '0, exp_bad = '0;
    bit           chk_en = 1'b1;
    int           checks = 0, errors = 0;
    int           run = 0, last_run = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [W-1:0] model_load(input logic [W-1:0] a, input int nb, input bit u);
        int base;
        logic [W-1:0] v;
        base = int'(a[IX+1:0]);
        v = '0;
        for (int k = 0; k < nb; k++) v[8*k +: 8] = mem_m[base+k];
        if (!u && nb < 4 && v[8*nb-1]) begin
            for (int k = 8*nb; k < W; k++) v[k] = 1'b1;
        end
        return v;
    endfunction

    task automatic model_store(input logic [W-1:0] a, input logic [W-1:0] d, input int nb);
        int base;
        base = int'(a[IX+1:0]);
        for (int k = 0; k < nb; k++) mem_m[base+k] = d[8*k +: 8];
    endtask

    // One cycle: wait for the edge, then randomise the branch inputs.
    task automatic tick();
        @(posedge clk);
        #1;
        br   = 1'($urandom_range(0, 1));
        brn  = 1'($urandom_range(0, 1));
        zero = 1'($urandom_range(0, 1));
    endtask

    // Compare every cycle, mid-cycle.
    always @(negedge clk) begin
        if (stall) run++;
        else begin
            if (run != 0) last_run = run;
            run = 0;
        end
        if (chk_en) begin
            chk("stall_out", 32'(stall), 32'(exp_stall));
            chk("valid_out", 32'(valid), 32'(exp_valid));
            chk("data_out", dout, exp_data);
            chk("misalign_out", 32'(mis), 32'(exp_mis));
            chk("bad_addr_out", bad, exp_bad);
            chk("pc_src_out", 32'(pc_src), 32'((br & zero) | (brn & ~zero)));
        end
    end

    // One request from IDLE, carried through to its last observable effect.
    task automatic op(input bit w, input bit r, input logic [W-1:0] a,
                      input logic [W-1:0] d, input logic [1:0] sz, input bit u);
        int nb;
        bit bad_al;
        logic [W-1:0] ev;
        nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        bad_al = (int'(a[1:0]) % nb) != 0;
        we = w; re = r; addr = a; wdata = d; msz = sz; uns = u;
        exp_valid = 1'b0; exp_mis = 1'b0; exp_stall = 1'b0;
        if ((w || r) && bad_al) begin
            tick();
            we = 1'b0; re = 1'b0;
            exp_mis = 1'b1; exp_bad = a;
            tick();
            exp_mis = 1'b0;
        end else if (w) begin
            tick();
            model_store(a, d, nb);
        end else if (r) begin
            ev = model_load(a, nb, u);
            exp_stall = 1'b1;
            tick();
            for (int i = 0; i < LAT; i++) begin
                we = 1'($urandom_range(0, 1));
                re = 1'($urandom_range(0, 1));
                exp_stall = 1'b1;
                tick();
            end
            we = 1'b0; re = 1'b0;
            exp_stall = 1'b0; exp_valid = 1'b1; exp_data = ev;
            tick();
            exp_valid = 1'b0;
        end else begin
            tick();
        end
    endtask

    initial begin
        logic [1:0]   rsz;
        logic [W-1:0] ra;
        int           kind;

        // Reset state
        tick();
        chk("reset_data", dout, 32'h0);
        chk("reset_stall", 32'(stall), 32'h0);
        tick();
        rst = 1'b0;
        tick();

        // Fill the whole memory, upper address bits random (wrap)
        for (int i = 0; i < (1 << IX); i++) begin
            ra = ($urandom & ~32'h7F) | (i * 4);
            op(1'b1, 1'b0, ra, $urandom, 2'd2, 1'b0);
        end

        op(1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 2'd2, 1'b0);
        op(1'b0, 1'b1, 32'h10, 32'h0, 2'd2, 1'b0);
        chk("lw_10", dout, 32'hDEADBEEF);
        chk("lw_stall_len", 32'(last_run), 32'(LAT + 1));
        op(1'b0, 1'b1, 32'h13, 32'h0, 2'd0, 1'b0);
        chk("lb_13", dout, 32'hFFFFFFDE);
        op(1'b0, 1'b1, 32'h13, 32'h0, 2'd0, 1'b1);
        chk("lbu_13", dout, 32'h000000DE);
        op(1'b0, 1'b1, 32'h12, 32'h0, 2'd1, 1'b0);
        chk("lh_12", dout, 32'hFFFFDEAD);
        op(1'b0, 1'b1, 32'h10, 32'h0, 2'd1, 1'b1);
        chk("lhu_10", dout, 32'h0000BEEF);
        op(1'b1, 1'b0, 32'h11, 32'h55, 2'd0, 1'b0);
        op(1'b0, 1'b1, 32'h10, 32'h0, 2'd2, 1'b0);
        chk("sb_then_lw", dout, 32'hDEAD55EF);

        // Misaligned load and store: no access, address reported
        op(1'b0, 1'b1, 32'h12, 32'h0, 2'd2, 1'b0);
        chk("mis_bad_addr", bad, 32'h12);
        op(1'b1, 1'b0, 32'h12, 32'h12345678, 2'd2, 1'b0);
        op(1'b0, 1'b1, 32'h10, 32'h0, 2'd2, 1'b0);
        chk("mis_mem_kept", dout, 32'hDEAD55EF);

        // Store wins over a simultaneous load; upper address bits wrap
        op(1'b1, 1'b1, 32'h40, 32'h01020304, 2'd2, 1'b0);
        op(1'b0, 1'b1, 32'h40, 32'h0, 2'd2, 1'b0);
        chk("we_re_both", dout, 32'h01020304);
        op(1'b1, 1'b0, 32'h80000020, 32'hCAFEF00D, 2'd2, 1'b0);
        op(1'b0, 1'b1, 32'h20, 32'h0, 2'd2, 1'b0);
        chk("addr_wrap", dout, 32'hCAFEF00D);

        // Branch decision
        br = 1'b1; brn = 1'b0; zero = 1'b1;
        #1 chk("beq_taken", 32'(pc_src), 32'h1);
        br = 1'b0; brn = 1'b1; zero = 1'b1;
        #1 chk("bne_not_taken", 32'(pc_src), 32'h0);
        tick();

        // Reset in the third WAIT cycle aborts the load
        we = 1'b0; re = 1'b1; addr = 32'h10; msz = 2'd2; uns = 1'b0;
        exp_stall = 1'b1; exp_valid = 1'b0; exp_mis = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        exp_stall = 1'b0; exp_data = '0; exp_bad = '0;
        #1 chk("rst_stall_now", 32'(stall), 32'h0);
        tick();
        re = 1'b0; rst = 1'b0;
        for (int i = 0; i < LAT + 2; i++) tick();
        chk("abort_run", 32'(last_run), 32'h3);
        op(1'b0, 1'b1, 32'h10, 32'h0, 2'd2, 1'b0);
        chk("lw_after_rst", dout, 32'hDEAD55EF);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            rsz  = 2'($urandom_range(0, 3));
            ra   = $urandom;
            kind = $urandom_range(0, 9);
            if ($urandom_range(0, 3) != 0) begin
                if (rsz == 2'd1) ra[0] = 1'b0;
                else if (rsz[1]) ra[1:0] = 2'b00;
            end
            op(kind < 4 || kind == 8, (kind >= 4 && kind < 9), ra, $urandom, rsz,
               1'($urandom_range(0, 1)));
        end

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_lsu.md
MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  WIDTH    32  data/address width in bits
  INDEX    5   word-address bits; memory depth 2**INDEX words
  LATENCY  1   load read latency in cycles, legal 1..4
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  clk_in          in   1                 single clock, rising edge
  rst_in          in   1                 asynchronous, active-high reset
  we_in           in   1                 store request
  re_in           in   1                 load request
  zero_in         in   1                 ALU zero flag
  ctrl_vector_in  in   riscv_control_t   branch, branch_neq, mem_size, mem_unsigned
  address_in      in   WIDTH             byte address
  data_in         in   WIDTH             store data, right-aligned
  pc_src_out      out  1                 branch taken
  stall_out       out  1                 hold upstream pipeline
  valid_out       out  1                 data_out holds new load data, one-cycle pulse
  data_out        out  WIDTH             extended load data, registered
  misalign_out    out  1                 misaligned-access pulse, registered
  bad_addr_out    out  WIDTH             address of last misaligned access

Function
REQ-003 pc_src_out SHALL be combinational: (branch & zero_in) | (branch_neq & ~zero_in).
REQ-004 Storage SHALL be 2**INDEX words of WIDTH bits with per-byte write enables; the word index SHALL be address_in[INDEX+1:2]; upper address bits SHALL be ignored (wrap).
REQ-005 mem_size SHALL select byte (00), half (01) or word (10); size 11 SHALL be treated as word.
REQ-006 An access SHALL be misaligned when size is half and address_in[0]=1, or size is word and address_in[1:0]!=0.
REQ-007 If we_in and re_in are both high, the store SHALL be performed and the load ignored.
REQ-008 FSM states SHALL be IDLE and WAIT; reset state IDLE.
REQ-009 In IDLE, an aligned store SHALL write the selected byte lanes at that clock edge from data_in[7:0] or [15:0], replicated to the addressed lane; no stall.
REQ-010 In IDLE, an aligned load SHALL assert stall_out combinationally in the same cycle, load counter with LATENCY-1, and go to WAIT.
REQ-011 In WAIT, stall_out SHALL be 1; counter SHALL decrement each cycle; when counter is 0 the extended lane SHALL be registered into data_out, valid_out SHALL pulse in the following cycle, and state SHALL return to IDLE.
REQ-012 Load-to-valid latency SHALL be LATENCY+1 cycles; stall_out SHALL be high for exactly LATENCY+1 consecutive cycles.
REQ-013 Loaded byte/half SHALL be zero-extended when mem_unsigned=1, else sign-extended from bit 7 or 15.
REQ-014 we_in/re_in received in WAIT SHALL be ignored; upstream holds its inputs stable while stall_out=1.
REQ-015 A misaligned request in IDLE SHALL perform no memory access and no stall; misalign_out SHALL pulse for one cycle on the next cycle with bad_addr_out = address_in.
REQ-016 data_out and bad_addr_out SHALL hold their values until next updated.

Reset
REQ-017 Asserting rst_in SHALL force, immediately: state IDLE, counter 0, stall_out 0, valid_out 0, misalign_out 0, data_out 0, bad_addr_out 0.
REQ-018 Reset during WAIT SHALL abort the load without any valid_out pulse.
REQ-019 Memory contents SHALL NOT be reset.

Structure
REQ-020 riscv_types SHALL gain mem_size_t (MEM_B, MEM_H, MEM_W) and riscv_control_t fields mem_size and mem_unsigned.
REQ-021 Byte-lane select and extension SHALL be a combinational sub-module lsu_align; select_branch SHALL be reused for REQ-003.

Verification
REQ-022 sw 0xDEADBEEF @0x10, then lw @0x10, LATENCY=1 -> stall_out high 2 cycles, valid_out on cycle 2, data_out=0xDEADBEEF.
REQ-023 lb @0x13 -> 0xFFFFFFDE; lbu @0x13 -> 0x000000DE; lh @0x12 -> 0xFFFFDEAD; lhu @0x10 -> 0x0000BEEF.
REQ-024 sb 0x55 @0x11, then lw @0x10 -> 0xDEAD55EF.
REQ-025 lw @0x12 -> no stall, misalign_out pulse next cycle, bad_addr_out=0x12, memory unchanged.
REQ-026 LATENCY=4, rst_in asserted in 3rd WAIT cycle -> stall_out 0 immediately, no valid_out, next lw completes normally.
REQ-027 branch=1, zero_in=1 -> pc_src_out=1; branch_neq=1, zero_in=1 -> pc_src_out=0.
